muldiv_sequencer: RTL and testbench

Iterative multiply/divide controller with HI/LO register ownership for the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests issued from the decode stage. Multiply and divide run as 32-iteration shift-add or restoring-divide sequences. While a sequence is in flight, the block asserts a stall back to decode so that no dependent or conflicting HI/LO access can proceed.

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 160 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Decode-side handshake bundle for the HI/LO multiply/divide sequencer.
interface muldiv_sequencer_if;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic        hz_clear;
  logic        md_stall;
  logic        md_busy;
  logic        md_done;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic [31:0] md_result;

  modport master (
    output md_start, md_op, md_opA, md_opB, hz_clear,
    input  md_stall, md_busy, md_done, md_hi, md_lo, md_result
  );

  modport slave (
    input  md_start, md_op, md_opA, md_opB, hz_clear,
    output md_stall, md_busy, md_done, md_hi, md_lo, md_result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit multiply/divide sequencer owning the architectural HI/LO registers.
module muldiv_sequencer (
  input logic             clock,
  input logic             reset,
  muldiv_sequencer_if.slave md
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;        // P_hi for multiply, partial remainder for divide
  logic [31:0] quo_q, quo_d;        // P_lo for multiply, quotient for divide
  logic [31:0] addend_q, addend_d;  // |A| for multiply, |B| for divide
  logic [31:0] opa_q, opa_d;        // raw dividend, returned in HI on divide by zero
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic        busy_q, done_q, done_d;

  logic        accept;
  logic        is_signed;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_trial;
  logic [63:0] prod;

  assign accept    = md.md_start && !busy_q && !md.hz_clear;
  assign is_signed = !md.md_op[0];
  assign mag_a     = (is_signed && md.md_opA[31]) ? (32'd0 - md.md_opA) : md.md_opA;
  assign mag_b     = (is_signed && md.md_opB[31]) ? (32'd0 - md.md_opB) : md.md_opB;

  // Datapath helpers for one multiply or divide iteration and the final product.
  always_comb begin
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, addend_q} : 33'd0);
    div_shift = {rem_q, quo_q[31]};
    div_trial = {1'b0, div_shift} - {2'b00, addend_q};
    prod      = {rem_q, quo_q};
  end

  // Next-state logic: accept, iterate, sign-correct and retire.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    addend_d = addend_q;
    opa_d    = opa_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!md.md_op[2]) begin
            state_d  = StRun;
            cnt_d    = 5'd31;
            is_div_d = md.md_op[1];
            opa_d    = md.md_opA;
            neg_lo_d = is_signed && (md.md_opA[31] ^ md.md_opB[31]);
            neg_hi_d = is_signed && md.md_opA[31];
            rem_d    = 32'd0;
            quo_d    = md.md_op[1] ? mag_a : mag_b;
            addend_d = md.md_op[1] ? mag_b : mag_a;
          end else begin
            done_d = 1'b1;
            case (md.md_op[1:0])
              2'd0:    hi_d  = md.md_opA;
              2'd1:    lo_d  = md.md_opA;
              2'd2:    res_d = hi_q;
              default: res_d = lo_q;
            endcase
          end
        end
      end
      StRun: begin
        if (is_div_q) begin
          // Trial is non-negative only when both top bits are clear; bit 32 never sets otherwise.
          if (div_trial[33:32] == 2'b00) begin
            rem_d = div_trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = div_shift[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
        end else begin
          rem_d = mul_sum[32:1];
          quo_d = {mul_sum[0], quo_q[31:1]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_lo_q ? (64'd0 - prod) : prod;
        end else if (addend_q == 32'd0) begin
          hi_d = opa_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          lo_d = neg_lo_q ? (32'd0 - quo_q) : quo_q;
          hi_d = neg_hi_q ? (32'd0 - rem_q) : rem_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and architectural register update with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      addend_q <= 32'd0;
      opa_q    <= 32'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_q    <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      addend_q <= addend_d;
      opa_q    <= opa_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= done_d;
    end
  end

  assign md.md_stall  = md.md_start && busy_q && !md.hz_clear;
  assign md.md_busy   = busy_q;
  assign md.md_done   = done_q;
  assign md.md_hi     = hi_q;
  assign md.md_lo     = lo_q;
  assign md.md_result = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized bench for the multiply/divide sequencer against an arithmetic model.
module tb_muldiv_sequencer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  muldiv_sequencer_if md ();

  muldiv_sequencer dut (
    .clock (clock),
    .reset (reset),
    .md    (md)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] m_hi, m_lo, m_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Architectural effect of one op, from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else if (op == 3'd2) begin
          sp = sa / sb; m_lo = sp[31:0];
          sp = sa % sb; m_hi = sp[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      3'd6: m_res = m_hi;
      default: m_res = m_lo;
    endcase
  endtask

  // Issue one op from idle, wait (bounded) for md_done, then check latency and state.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    int cyc;
    md.md_start = 1'b1;
    md.md_op    = op;
    md.md_opA   = a;
    md.md_opB   = b;
    step();
    md.md_start = 1'b0;
    cyc = 1;
    if (!op[2]) check({tag, "_busy1"}, 32'(md.md_busy), 32'd1);
    while (md.md_done !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    model(op, a, b);
    check({tag, "_latency"}, 32'(cyc), op[2] ? 32'd1 : 32'd34);
    check({tag, "_busy_end"}, 32'(md.md_busy), 32'd0);
    check({tag, "_hi"}, md.md_hi, m_hi);
    check({tag, "_lo"}, md.md_lo, m_lo);
    check({tag, "_result"}, md.md_result, m_res);
    step();
    check({tag, "_done_pulse"}, 32'(md.md_done), 32'd0);
  endtask

  initial begin
    int nst;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset       = 1'b1;
    md.md_start = 1'b0;
    md.md_op    = 3'd0;
    md.md_opA   = 32'd0;
    md.md_opB   = 32'd0;
    md.hz_clear = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0;
    step();
    step();
    reset = 1'b0;
    check("rst_hi", md.md_hi, 32'd0);
    check("rst_lo", md.md_lo, 32'd0);
    check("rst_result", md.md_result, 32'd0);
    check("rst_busy", 32'(md.md_busy), 32'd0);
    check("rst_done", 32'(md.md_done), 32'd0);

    // Directed vectors
    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    check("mult_neg3x5_hi_k", md.md_hi, 32'hFFFF_FFFF);
    check("mult_neg3x5_lo_k", md.md_lo, 32'hFFFF_FFF1);
    do_op(3'd3, 32'd100, 32'd7, "divu_100_7");
    check("divu_lo_k", md.md_lo, 32'd14);
    check("divu_hi_k", md.md_hi, 32'd2);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    check("div_neg7_lo_k", md.md_lo, 32'hFFFF_FFFD);
    check("div_neg7_hi_k", md.md_hi, 32'hFFFF_FFFF);
    do_op(3'd2, 32'h1234_5678, 32'd0, "div_by0");
    check("div_by0_hi_k", md.md_hi, 32'h1234_5678);
    check("div_by0_lo_k", md.md_lo, 32'hFFFF_FFFF);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_lo_k", md.md_lo, 32'h8000_0000);
    check("div_ovf_hi_k", md.md_hi, 32'd0);

    // MULTU followed by MFHI held from cycle 1: stalled through the whole sequence
    md.md_start = 1'b1;
    md.md_op    = 3'd1;
    md.md_opA   = 32'hFFFF_FFFF;
    md.md_opB   = 32'hFFFF_FFFF;
    step();
    md.md_op = 3'd6;
    nst = 0;
    for (int c = 1; c <= 33; c++) begin
      if (md.md_stall === 1'b1) nst++;
      step();
    end
    check("stall_cycles", 32'(nst), 32'd33);
    check("c34_done", 32'(md.md_done), 32'd1);
    check("c34_busy", 32'(md.md_busy), 32'd0);
    check("c34_stall", 32'(md.md_stall), 32'd0);
    check("multu_hi", md.md_hi, 32'hFFFF_FFFE);
    check("multu_lo", md.md_lo, 32'h0000_0001);
    step();
    md.md_start = 1'b0;
    model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    model(3'd6, 32'd0, 32'd0);
    check("mfhi_done", 32'(md.md_done), 32'd1);
    check("mfhi_result", md.md_result, 32'hFFFF_FFFE);
    step();
    check("mfhi_done_pulse", 32'(md.md_done), 32'd0);

    // MTLO squashed by hz_clear, then accepted
    md.md_start = 1'b1;
    md.md_op    = 3'd5;
    md.md_opA   = 32'hCAFE_BABE;
    md.hz_clear = 1'b1;
    check("squash_stall", 32'(md.md_stall), 32'd0);
    step();
    check("squash_lo", md.md_lo, m_lo);
    check("squash_done", 32'(md.md_done), 32'd0);
    md.hz_clear = 1'b0;
    step();
    md.md_start = 1'b0;
    check("mtlo_lo", md.md_lo, 32'hCAFE_BABE);
    check("mtlo_hi", md.md_hi, m_hi);
    check("mtlo_done", 32'(md.md_done), 32'd1);
    model(3'd5, 32'hCAFE_BABE, 32'd0);
    step();

    // Reset in the middle of a MULT
    md.md_start = 1'b1;
    md.md_op    = 3'd0;
    md.md_opA   = 32'd123;
    md.md_opB   = 32'd456;
    step();
    md.md_start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0;
    check("midrst_busy", 32'(md.md_busy), 32'd0);
    check("midrst_hi", md.md_hi, 32'd0);
    check("midrst_lo", md.md_lo, 32'd0);
    check("midrst_done", 32'(md.md_done), 32'd0);
    nst = 0;
    for (int c = 0; c < 30; c++) begin
      if (md.md_done === 1'b1) nst++;
      step();
    end
    check("midrst_no_done", 32'(nst), 32'd0);
    do_op(3'd0, 32'd6, 32'd7, "mult_6x7");
    check("mult_6x7_k", md.md_lo, 32'd42);

    // Randomized mix of all eight ops
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      do_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
